// File: rtl/id_stage_pkg.sv
// Shared decode constants, branch payload type and offset helpers for the ID stage.
package id_stage_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned OPC_W  = 6;
    localparam int unsigned REG_AW = 5;

    localparam logic [OPC_W-1:0] OP_JIRL = 6'b010011;
    localparam logic [OPC_W-1:0] OP_B    = 6'b010100;
    localparam logic [OPC_W-1:0] OP_BL   = 6'b010101;
    localparam logic [OPC_W-1:0] OP_BEQ  = 6'b010110;
    localparam logic [OPC_W-1:0] OP_BNE  = 6'b010111;

    localparam logic [XLEN-1:0] RESET_PC = 32'h1C00_0000;

    // Redirect request produced by the branch unit.
    typedef struct packed {
        logic            taken;
        logic [XLEN-1:0] target;
    } br_res_t;

    // Sign-extend a 16-bit word offset and convert it to a byte offset.
    function automatic logic [XLEN-1:0] SEXT16_SH2(input logic [15:0] offs);
        return {{14{offs[15]}}, offs, 2'b00};
    endfunction

    // Sign-extend a 26-bit word offset and convert it to a byte offset.
    function automatic logic [XLEN-1:0] SEXT26_SH2(input logic [25:0] offs);
        return {{4{offs[25]}}, offs, 2'b00};
    endfunction

endpackage

// File: rtl/id_stage_br_unit.sv
// Combinational control-flow resolver: (inst, pc, rj, rkd) -> (taken, target).
module id_stage_br_unit
    import id_stage_pkg::*;
(
    input  logic [XLEN-1:0] inst,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rj_value,
    input  logic [XLEN-1:0] rkd_value,
    output br_res_t         br_c
);

    logic [OPC_W-1:0] opcode;
    logic [15:0]      offs16;
    logic [25:0]      offs26;

    assign opcode = inst[31:26];
    assign offs16 = inst[25:10];
    assign offs26 = {inst[9:0], inst[25:10]};

    // Resolve condition and target; target reads as zero when not taken.
    always_comb begin
        br_c = '0;
        case (opcode)
            OP_JIRL: begin
                br_c.taken  = 1'b1;
                br_c.target = rj_value + SEXT16_SH2(offs16);
            end
            OP_B, OP_BL: begin
                br_c.taken  = 1'b1;
                br_c.target = pc + SEXT26_SH2(offs26);
            end
            OP_BEQ: begin
                if (rj_value == rkd_value) begin
                    br_c.taken  = 1'b1;
                    br_c.target = pc + SEXT16_SH2(offs16);
                end
            end
            OP_BNE: begin
                if (rj_value != rkd_value) begin
                    br_c.taken  = 1'b1;
                    br_c.target = pc + SEXT16_SH2(offs16);
                end
            end
            default: br_c = '0;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: pipeline register, source reads and branch redirect.
module id_stage
    import id_stage_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              if_to_id_valid,
    input  logic [XLEN-1:0]   if_inst,
    input  logic [XLEN-1:0]   if_pc,
    output logic              id_allowin,
    output logic              br_taken,
    output logic [XLEN-1:0]   br_target,
    output logic [REG_AW-1:0] rf_raddr1,
    output logic [REG_AW-1:0] rf_raddr2,
    input  logic [XLEN-1:0]   rf_rdata1,
    input  logic [XLEN-1:0]   rf_rdata2,
    input  logic              ex_allowin,
    output logic              id_to_ex_valid,
    output logic [XLEN-1:0]   id_inst,
    output logic [XLEN-1:0]   id_pc,
    output logic [XLEN-1:0]   id_rj_value,
    output logic [XLEN-1:0]   id_rkd_value
);

    logic             id_valid;
    logic             id_ready_go;
    logic [OPC_W-1:0] id_opcode;
    br_res_t          br_res;

    assign id_ready_go    = 1'b1;
    assign id_allowin     = ~id_valid | (id_ready_go & ex_allowin);
    assign id_to_ex_valid = id_valid & id_ready_go;

    // Pipeline register; the instruction accepted on a redirect edge is wrong-path and dropped.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            id_valid <= 1'b0;
            id_inst  <= '0;
            id_pc    <= '0;
        end else if (id_allowin) begin
            id_valid <= if_to_id_valid & ~br_taken;
            id_inst  <= if_inst;
            id_pc    <= if_pc;
        end
    end

    // Register-file addressing: branches compare rj against rd, everything else reads rk.
    assign id_opcode    = id_inst[31:26];
    assign rf_raddr1    = id_inst[9:5];
    assign rf_raddr2    = ((id_opcode == OP_BEQ) || (id_opcode == OP_BNE)) ? id_inst[4:0]
                                                                           : id_inst[14:10];
    assign id_rj_value  = rf_rdata1;
    assign id_rkd_value = rf_rdata2;

    id_stage_br_unit u_br_unit (
        .inst      (id_inst),
        .pc        (id_pc),
        .rj_value  (rf_rdata1),
        .rkd_value (rf_rdata2),
        .br_c      (br_res)
    );

    assign br_taken  = id_valid & br_res.taken;
    assign br_target = br_taken ? br_res.target : '0;

endmodule

// File: tb/tb_id_stage.sv
// Directed and randomized checks of id_stage against an arithmetic reference model.
module tb_id_stage;

    logic        clk;
    logic        resetn;
    logic        if_to_id_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        id_allowin;
    logic        br_taken;
    logic [31:0] br_target;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic        ex_allowin;
    logic        id_to_ex_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_rj_value;
    logic [31:0] id_rkd_value;

    logic [31:0] regs [32];

    int checks = 0;
    int errors = 0;

    // Reference state of the ID slot
    logic        m_valid = 1'b0;
    logic [31:0] m_inst  = '0;
    logic [31:0] m_pc    = '0;

    assign rf_rdata1 = regs[rf_raddr1];
    assign rf_rdata2 = regs[rf_raddr2];

    id_stage dut (
        .clk            (clk),
        .resetn         (resetn),
        .if_to_id_valid (if_to_id_valid),
        .if_inst        (if_inst),
        .if_pc          (if_pc),
        .id_allowin     (id_allowin),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .rf_raddr1      (rf_raddr1),
        .rf_raddr2      (rf_raddr2),
        .rf_rdata1      (rf_rdata1),
        .rf_rdata2      (rf_rdata2),
        .ex_allowin     (ex_allowin),
        .id_to_ex_valid (id_to_ex_valid),
        .id_inst        (id_inst),
        .id_pc          (id_pc),
        .id_rj_value    (id_rj_value),
        .id_rkd_value   (id_rkd_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk16(input logic [5:0] op, input logic [15:0] off,
                                         input logic [4:0] rj, input logic [4:0] rd);
        return {op, off, rj, rd};
    endfunction

    function automatic logic [31:0] mk26(input logic [5:0] op, input logic [25:0] off);
        return {op, off[15:0], off[25:16]};
    endfunction

    localparam logic [31:0] ADDI = {10'b0000001010, 12'd1, 5'd2, 5'd3};

    // Architectural branch behaviour computed with signed integer offsets.
    task automatic ref_branch(input logic [31:0] inst, input logic [31:0] pc,
                              output logic tk, output logic [31:0] tg);
        logic [5:0]  op;
        logic [15:0] f16;
        logic [25:0] f26;
        logic [31:0] rj;
        logic [31:0] rd;
        int          o16;
        int          o26;
        op  = inst[31:26];
        f16 = inst[25:10];
        f26 = {inst[9:0], inst[25:10]};
        o16 = 4 * int'($signed(f16));
        o26 = 4 * int'($signed(f26));
        rj  = regs[inst[9:5]];
        rd  = regs[inst[4:0]];
        tk  = 1'b0;
        tg  = '0;
        case (op)
            6'b010011: begin tk = 1'b1;       tg = rj + 32'(o16); end
            6'b010100,
            6'b010101: begin tk = 1'b1;       tg = pc + 32'(o26); end
            6'b010110: begin tk = (rj == rd); tg = pc + 32'(o16); end
            6'b010111: begin tk = (rj != rd); tg = pc + 32'(o16); end
            default:   begin tk = 1'b0;       tg = '0;            end
        endcase
        if (!tk) tg = '0;
    endtask

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    // Compare every output against the reference slot.
    task automatic check_all();
        logic        tk;
        logic [31:0] tg;
        logic [4:0]  ra2;
        ref_branch(m_inst, m_pc, tk, tg);
        tk = tk & m_valid;
        if (!tk) tg = '0;
        ra2 = (m_inst[31:26] == 6'b010110 || m_inst[31:26] == 6'b010111) ? m_inst[4:0]
                                                                         : m_inst[14:10];
        chk("id_to_ex_valid", 32'(id_to_ex_valid), 32'(m_valid));
        chk("id_allowin",     32'(id_allowin),     32'(!m_valid || ex_allowin));
        chk("br_taken",       32'(br_taken),       32'(tk));
        chk("br_target",      br_target,           tg);
        chk("id_inst",        id_inst,             m_inst);
        chk("id_pc",          id_pc,               m_pc);
        chk("rf_raddr1",      32'(rf_raddr1),      32'(m_inst[9:5]));
        chk("rf_raddr2",      32'(rf_raddr2),      32'(ra2));
        chk("id_rj_value",    id_rj_value,         regs[m_inst[9:5]]);
        chk("id_rkd_value",   id_rkd_value,        regs[ra2]);
    endtask

    task automatic drive(input logic rst, input logic v, input logic [31:0] inst,
                         input logic [31:0] pc, input logic exa);
        resetn         = rst;
        if_to_id_valid = v;
        if_inst        = inst;
        if_pc          = pc;
        ex_allowin     = exa;
        #1;
        check_all();
    endtask

    // Advance one edge and update the reference slot from the pre-edge state.
    task automatic tick();
        logic        tk;
        logic [31:0] tg;
        ref_branch(m_inst, m_pc, tk, tg);
        tk = tk & m_valid;
        @(posedge clk);
        if (!resetn) begin
            m_valid = 1'b0;
            m_inst  = '0;
            m_pc    = '0;
        end else if (!m_valid || ex_allowin) begin
            m_valid = if_to_id_valid & !tk;
            m_inst  = if_inst;
            m_pc    = if_pc;
        end
        #1;
    endtask

    initial begin
        logic [5:0]  ops [6];
        logic [31:0] inst;
        logic [31:0] pc;
        ops = '{6'b010011, 6'b010100, 6'b010101, 6'b010110, 6'b010111, 6'b000000};
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        resetn         = 1'b0;
        if_to_id_valid = 1'b0;
        if_inst        = '0;
        if_pc          = '0;
        ex_allowin     = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;

        // Reset state, then a plain instruction
        drive(1, 1, ADDI, 32'h1C00_0000, 1);
        chk("rst_allowin", 32'(id_allowin), 32'd1);
        chk("rst_valid",   32'(id_to_ex_valid), 32'd0);
        chk("rst_target",  br_target, 32'd0);
        tick();
        drive(1, 1, mk26(6'b010100, 26'd4), 32'h1C00_0010, 1);
        chk("addi_pc",    id_pc, 32'h1C00_0000);
        chk("addi_valid", 32'(id_to_ex_valid), 32'd1);
        chk("addi_taken", 32'(br_taken), 32'd0);
        tick();

        // b with offs26 = 4
        drive(1, 1, ADDI, 32'h1C00_0014, 1);
        chk("b_taken",  32'(br_taken), 32'd1);
        chk("b_target", br_target, 32'h1C00_0020);
        tick();
        drive(1, 1, ADDI, 32'h1C00_0020, 1);
        chk("b_squash", 32'(id_to_ex_valid), 32'd0);
        tick();

        // beq equal then not equal
        regs[3] = 32'd5;
        regs[4] = 32'd5;
        drive(1, 1, mk16(6'b010110, 16'd8, 5'd3, 5'd4), 32'h1C00_0024, 1);
        tick();
        drive(1, 1, ADDI, 32'h1C00_0028, 1);
        chk("beq_eq_taken",  32'(br_taken), 32'd1);
        chk("beq_eq_target", br_target, 32'h1C00_0044);
        tick();
        drive(1, 1, mk16(6'b010110, 16'd8, 5'd3, 5'd4), 32'h1C00_0044, 1);
        tick();
        regs[4] = 32'd6;
        drive(1, 1, ADDI, 32'h1C00_0048, 1);
        chk("beq_ne_taken", 32'(br_taken), 32'd0);
        tick();
        drive(1, 1, ADDI, 32'h1C00_004C, 1);
        chk("beq_ne_next_valid", 32'(id_to_ex_valid), 32'd1);
        chk("beq_ne_next_pc",    id_pc, 32'h1C00_0048);
        tick();

        // jirl with negative offset
        regs[7] = 32'h1C00_0100;
        drive(1, 1, mk16(6'b010011, 16'hFFFF, 5'd7, 5'd1), 32'h1C00_0050, 1);
        tick();
        drive(1, 1, ADDI, 32'h1C00_0054, 1);
        chk("jirl_taken",  32'(br_taken), 32'd1);
        chk("jirl_target", br_target, 32'h1C00_00FC);
        tick();

        // Taken bne held under a 3-cycle stall
        drive(1, 1, mk16(6'b010111, 16'd16, 5'd3, 5'd4), 32'h1C00_00FC, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, ADDI, 32'h1C00_0100, 0);
            chk("stall_taken",   32'(br_taken), 32'd1);
            chk("stall_allowin", 32'(id_allowin), 32'd0);
            chk("stall_pc",      id_pc, 32'h1C00_00FC);
            tick();
        end
        drive(1, 1, ADDI, 32'h1C00_0100, 1);
        chk("release_target", br_target, 32'h1C00_013C);
        tick();
        drive(1, 1, ADDI, 32'h1C00_013C, 1);
        chk("release_squash", 32'(id_to_ex_valid), 32'd0);
        tick();

        // Reset during a stalled taken branch
        drive(1, 1, mk26(6'b010100, 26'd4), 32'h1C00_0200, 1);
        tick();
        drive(1, 1, ADDI, 32'h1C00_0204, 0);
        chk("pre_rst_taken", 32'(br_taken), 32'd1);
        tick();
        drive(0, 1, ADDI, 32'h1C00_0204, 0);
        tick();
        drive(1, 0, '0, '0, 0);
        chk("mid_rst_taken", 32'(br_taken), 32'd0);
        chk("mid_rst_valid", 32'(id_to_ex_valid), 32'd0);
        chk("mid_rst_pc",    id_pc, 32'd0);
        tick();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0)
                regs[$urandom_range(0, 7)] = 32'($urandom_range(0, 3)) | (($urandom_range(0, 1) == 1) ? 32'h1C00_0000 : 32'h0);
            inst = $urandom;
            inst[31:26] = ops[$urandom_range(0, 5)];
            inst[9:5]   = 5'($urandom_range(0, 7));
            inst[4:0]   = 5'($urandom_range(0, 7));
            pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0), inst, pc,
                  ($urandom_range(0, 2) != 0));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
